// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store unit between the core execute stage and a
// data bus with wait states. One transaction at a time: IDLE -> REQ -> WAIT
// -> DONE. Loads are byte/half extracted and sign/zero extended. Stores are
// lane-replicated with byte strobes.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned half/word accesses
// return an error response without touching the bus).
module load_store_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  busy,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_wstrb,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_t;

    state_t                state;
    logic [2:0]            f3_q;
    logic [1:0]            lo_q;
    logic [CNT_W-1:0]      cnt;

    logic                  req_legal;
    logic                  req_misalign;
    logic [3:0]            req_strb;
    logic [DATA_WIDTH-1:0] req_wfmt;

    // Select the addressed lane and extend it according to the load type
    function automatic logic [DATA_WIDTH-1:0] extract(
        input logic [2:0]            f3,
        input logic [1:0]            lo,
        input logic [DATA_WIDTH-1:0] word
    );
        logic [7:0]  b;
        logic [15:0] h;
        case (lo)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lo[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    extract = {{24{b[7]}}, b};
            F3_H:    extract = {{16{h[15]}}, h};
            F3_BU:   extract = {24'd0, b};
            F3_HU:   extract = {16'd0, h};
            default: extract = word;
        endcase
    endfunction

    // Decode the incoming request: legality, alignment and store lane formatting
    always_comb begin
        req_legal    = 1'b0;
        req_misalign = 1'b0;
        req_strb     = '0;
        req_wfmt     = '0;
        if (req_we) begin
            case (req_funct3)
                F3_B: begin
                    req_legal = 1'b1;
                    req_strb  = 4'b0001 << req_addr[1:0];
                    req_wfmt  = {4{req_wdata[7:0]}};
                end
                F3_H: begin
                    req_legal = 1'b1;
                    req_strb  = req_addr[1] ? 4'b1100 : 4'b0011;
                    req_wfmt  = {2{req_wdata[15:0]}};
                end
                F3_W: begin
                    req_legal = 1'b1;
                    req_strb  = 4'b1111;
                    req_wfmt  = req_wdata;
                end
                default: ;
            endcase
        end else begin
            case (req_funct3)
                F3_B, F3_H, F3_W, F3_BU, F3_HU: req_legal = 1'b1;
                default: ;
            endcase
        end
`ifdef LSU_MISALIGN_TRAP_EN
        case (req_funct3)
            F3_H, F3_HU: req_misalign = req_addr[0];
            F3_W:        req_misalign = |req_addr[1:0];
            default: ;
        endcase
`endif
    end

    // Transaction FSM; every output is registered here
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            f3_q       <= '0;
            lo_q       <= '0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wstrb  <= '0;
            mem_wdata  <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        f3_q      <= req_funct3;
                        lo_q      <= req_addr[1:0];
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (req_legal && !req_misalign) begin
                            state     <= REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= {req_addr[DATA_WIDTH-1:2], 2'b00};
                            mem_wstrb <= req_strb;
                            mem_wdata <= req_wfmt;
                        end else begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        if (mem_we) begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b0;
                            resp_rdata <= '0;
                        end else begin
                            state <= WAIT;
                            cnt   <= '0;
                        end
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        state      <= DONE;
                        cnt        <= '0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= extract(f3_q, lo_q, mem_rdata);
                    end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state      <= DONE;
                        cnt        <= '0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    req_ready  <= 1'b1;
                    busy       <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized and directed stimulus for load_store_unit,
// with a byte-array reference memory, a bus responder and a response
// scoreboard.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    load_store_unit #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .busy(busy), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          at;
    } resp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } bus_t;

    resp_t sb[$];
    bus_t  bq[$];

    logic [7:0]  ref_bytes [64];
    logic [31:0] bus_mem   [16];

    int gnt_fixed = -1;
    int rv_fixed  = -1;
    int rv_mode   = 0;   // 0 deliver read data, 1 hold it back, 2 discard it

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm, input string act, input string exp);
        checks++;
        errors++;
        $display("FAIL %s actual=%s required=%s", nm, act, exp);
    endtask

    function automatic int acc_size(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic bit is_legal(input logic we, input logic [2:0] f3);
        if (we) return f3 <= 3'd2;
        return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    endfunction

    function automatic logic [31:0] init_word(input int i);
        return 32'h9E37_79B9 * 32'(i + 1);
    endfunction

    // Present one request and record what the bus and the core should see
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int lat, input bit tmo);
        int n;
        int sz;
        int off;
        int eff;
        bit err;
        resp_t r;
        bus_t b;
        logic [31:0] v;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            fail("ready_wait", "stuck", "req_ready");
            return;
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;

        sz  = acc_size(f3);
        off = int'(addr[5:0]);
        eff = off - (off % sz);
        err = !is_legal(we, f3);
`ifdef LSU_MISALIGN_TRAP_EN
        if (off % sz != 0) err = 1'b1;
`endif
        r.rdata = '0;
        r.err   = err;
        r.at    = (lat < 0) ? -1 : cyc + lat;
        if (!err) begin
            b.we    = we;
            b.addr  = {addr[31:2], 2'b00};
            b.strb  = '0;
            b.wdata = '0;
            if (we) begin
                for (int k = 0; k < sz; k++) begin
                    ref_bytes[eff + k]   = wd[8*k +: 8];
                    b.strb[(eff % 4) + k] = 1'b1;
                end
                for (int i = 0; i < 4; i++) b.wdata[8*i +: 8] = wd[8*(i % sz) +: 8];
            end else if (tmo) begin
                r.err = 1'b1;
            end else begin
                v = '0;
                for (int k = 0; k < sz; k++) v[8*k +: 8] = ref_bytes[eff + k];
                if ((f3 == 3'b000 || f3 == 3'b001) && v[8*sz-1])
                    for (int k = sz; k < 4; k++) v[8*k +: 8] = 8'hFF;
                r.rdata = v;
            end
            bq.push_back(b);
        end
        sb.push_back(r);
        @(negedge clk);
        req_valid = 1'b0;
        req_wdata = $urandom;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || sb.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (busy || sb.size() != 0) fail("idle_wait", "busy", "idle");
    endtask

    // Bus responder: grants after a delay, returns read data, applies writes
    initial begin
        int gw;
        int rw;
        bit rpend;
        logic [31:0] raddr;
        gw = -1;
        rw = 0;
        rpend = 1'b0;
        raddr = '0;
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = '0;
        for (int i = 0; i < 16; i++) bus_mem[i] = init_word(i);
        forever begin
            @(negedge clk);
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            if (rpend) begin
                if (rv_mode == 2) begin
                    rpend = 1'b0;
                end else if (rv_mode == 0) begin
                    if (rw == 0) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = bus_mem[raddr[5:2]];
                        rpend      = 1'b0;
                    end else begin
                        rw--;
                    end
                end
            end else if (mem_req && !rst) begin
                if (gw < 0) gw = (gnt_fixed >= 0) ? gnt_fixed : int'($urandom_range(0, 3));
                if (bq.size() == 0) begin
                    fail("bus_req", "request", "no request");
                end else begin
                    chk("bus_we", 32'(mem_we), 32'(bq[0].we));
                    chk("bus_addr", mem_addr, bq[0].addr);
                    if (bq[0].we) begin
                        chk("bus_wstrb", 32'(mem_wstrb), 32'(bq[0].strb));
                        chk("bus_wdata", mem_wdata, bq[0].wdata);
                    end
                end
                if (gw == 0) begin
                    mem_gnt = 1'b1;
                    gw = -1;
                    if (bq.size() != 0) void'(bq.pop_front());
                    if (mem_we) begin
                        for (int i = 0; i < 4; i++)
                            if (mem_wstrb[i]) bus_mem[mem_addr[5:2]][8*i +: 8] = mem_wdata[8*i +: 8];
                    end else begin
                        rpend = 1'b1;
                        raddr = mem_addr;
                        rw    = (rv_fixed >= 0) ? rv_fixed : int'($urandom_range(0, 3));
                    end
                end else begin
                    gw--;
                    mem_rvalid = ($urandom_range(0, 3) == 0);
                end
            end
        end
    end

    // Response monitor: every completion pulse must match the next expectation
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            if (!rst && resp_valid) begin
                if (sb.size() == 0) begin
                    fail("resp_unexpected", "resp_valid", "none");
                end else begin
                    e = sb.pop_front();
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("resp_err", 32'(resp_err), 32'(e.err));
                    if (e.at >= 0) chk("resp_cycle", 32'(cyc), 32'(e.at));
                end
            end
        end
    end

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = '0;
        req_addr   = '0;
        req_wdata  = '0;
        for (int i = 0; i < 16; i++)
            for (int k = 0; k < 4; k++) ref_bytes[4*i + k] = init_word(i) >> (8*k);

        repeat (3) @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        rst = 1'b0;

        // Minimum-latency store and loads with byte/half extraction
        gnt_fixed = 0;
        rv_fixed  = 0;
        issue(1'b1, 3'b010, 32'h0000_0100, 32'h80FF_1234, 2, 1'b0);
        issue(1'b0, 3'b000, 32'h0000_0103, 32'h0, 3, 1'b0);
        issue(1'b1, 3'b010, 32'h0000_0200, 32'hBEEF_0000, 2, 1'b0);
        issue(1'b0, 3'b101, 32'h0000_0202, 32'h0, 3, 1'b0);
        issue(1'b0, 3'b001, 32'h0000_0202, 32'h0, 3, 1'b0);
        rv_fixed = 2;
        issue(1'b0, 3'b010, 32'h0000_0208, 32'h0, 5, 1'b0);

        // Grant delayed by three cycles
        gnt_fixed = 3;
        rv_fixed  = 0;
        issue(1'b1, 3'b000, 32'h0000_0301, 32'h0000_00A5, 5, 1'b0);
        issue(1'b0, 3'b100, 32'h0000_0301, 32'h0, 6, 1'b0);
        gnt_fixed = 0;

        // Illegal funct3 for load and store
        issue(1'b0, 3'b011, 32'h0000_0010, 32'h0, 1, 1'b0);
        issue(1'b1, 3'b011, 32'h0000_0010, 32'h1234_5678, 1, 1'b0);
        issue(1'b0, 3'b111, 32'h0000_0010, 32'h0, 1, 1'b0);

        // Read data never arrives
        rv_mode = 1;
        issue(1'b0, 3'b010, 32'h0000_0400, 32'h0, 66, 1'b1);
        wait_idle();
        chk("tmo_ready", 32'(req_ready), 32'd1);
        rv_mode = 2;
        repeat (2) @(negedge clk);
        rv_mode = 0;

        // Reset while waiting for read data; the late data must be ignored
        rv_mode = 1;
        issue(1'b0, 3'b010, 32'h0000_1004, 32'h0, -1, 1'b0);
        repeat (4) @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_mem_req", 32'(mem_req), 32'd0);
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        chk("abort_busy_clr", 32'(busy), 32'd0);
        rst = 1'b0;
        if (sb.size() != 0) void'(sb.pop_front());
        rv_mode = 0;
        repeat (6) @(negedge clk);
        issue(1'b0, 3'b010, 32'h0000_1004, 32'h0, 3, 1'b0);

        // Misaligned accesses
`ifdef LSU_MISALIGN_TRAP_EN
        issue(1'b1, 3'b010, 32'h0000_0502, 32'h1357_9BDF, 1, 1'b0);
        issue(1'b0, 3'b001, 32'h0000_0503, 32'h0, 1, 1'b0);
`else
        issue(1'b1, 3'b010, 32'h0000_0502, 32'h1357_9BDF, 2, 1'b0);
        issue(1'b0, 3'b001, 32'h0000_0503, 32'h0, 3, 1'b0);
`endif
        issue(1'b0, 3'b010, 32'h0000_0500, 32'h0, 3, 1'b0);

        // Randomized traffic with random grant and read-data delays
        gnt_fixed = -1;
        rv_fixed  = -1;
        for (int t = 0; t < 200; t++) begin
            logic        w;
            logic [2:0]  f;
            logic [31:0] a;
            w = 1'($urandom_range(0, 1));
            f = w ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            a = ($urandom & 32'hFFFF_FFC0) | 32'($urandom_range(0, 63));
            issue(w, f, a, $urandom, -1, 1'b0);
        end
        wait_idle();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("bus_drained", 32'(bq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
